// File: rtl/lut_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : lut_config_loader
// Purpose  : Serial-to-parallel configuration loader for a split LUT. It
//            shifts in CFG_BITS bits MSB-first, commits the full frame to a
//            holding register and pulses cen for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lut_config_loader #(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2**INPUTS
) (
  input  logic                  cclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [2*MEM_SIZE-1:0] config_out,
  output logic                  cen,
  output logic                  busy,
  output logic                  done
);

  localparam int CFG_BITS = 2*MEM_SIZE;
  localparam int c_cnt_w  = $clog2(CFG_BITS+1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CFG_BITS-1);

  // Each LUT half must hold one bit per input combination.
  generate
    if (MEM_SIZE < (1 << INPUTS)) begin : g_size_check
      $error("MEM_SIZE too small for INPUTS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                r_state,  w_next_state;
  logic [c_cnt_w-1:0]    r_count,  w_next_count;
  logic [CFG_BITS-1:0]   r_shadow, w_next_shadow;
  logic [CFG_BITS-1:0]   r_config, w_next_config;
  logic                  r_done,   w_next_done;
  logic [CFG_BITS-1:0]   w_shifted;

  assign w_shifted = {r_shadow[CFG_BITS-2:0], bit_in};

  // State and datapath registers; reset clears everything, including the
  // committed configuration.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_config <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_shadow <= w_next_shadow;
      r_config <= w_next_config;
      r_done   <= w_next_done;
    end
  end

  // Next-state logic: start always wins over a bit transfer, and the holding
  // register is only written when the final bit of a frame is accepted.
  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_shadow = r_shadow;
    w_next_config = r_config;
    w_next_done   = r_done;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SHIFT;
          w_next_count = '0;
          w_next_done  = 1'b0;
        end
      end
      SHIFT: begin
        if (start) begin
          w_next_count  = '0;
          w_next_shadow = '0;
          w_next_done   = 1'b0;
        end else if (bit_valid) begin
          w_next_shadow = w_shifted;
          w_next_count  = r_count + c_cnt_w'(1);
          if (r_count == c_last) begin
            w_next_config = w_shifted;
            w_next_state  = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (start) begin
          w_next_state = SHIFT;
          w_next_count = '0;
          w_next_done  = 1'b0;
        end else begin
          w_next_state = IDLE;
          w_next_done  = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign bit_ready  = (r_state == SHIFT);
  assign busy       = (r_state != IDLE);
  assign cen        = (r_state == COMMIT);
  assign done       = r_done;
  assign config_out = r_config;

endmodule
`default_nettype wire

// File: tb/tb_lut_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_config_loader
// Purpose  : Scoreboard bench for lut_config_loader with INPUTS=2 (8-bit
//            frames). Stimulus pushes expected frames; a monitor pops them on
//            each cen pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_config_loader;

  localparam int CFG_BITS = 8;

  logic                cclk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                bit_in = 1'b0;
  logic                bit_valid = 1'b0;
  logic                bit_ready;
  logic [CFG_BITS-1:0] config_out;
  logic                cen;
  logic                busy;
  logic                done;

  int                  total = 0;
  int                  bad = 0;
  int                  cen_seen = 0;
  logic [CFG_BITS-1:0] exp_q[$];
  logic [CFG_BITS-1:0] model_cfg = '0;

  lut_config_loader #(.INPUTS(2)) dut (
    .cclk       (cclk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .config_out (config_out),
    .cen        (cen),
    .busy       (busy),
    .done       (done)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Send one full frame MSB-first. mode 0: back-to-back bits,
  // 1: one idle cycle between bits, 2: random idle gaps.
  task automatic send_frame(input logic [CFG_BITS-1:0] value, input int mode);
    int gap;
    exp_q.push_back(value);
    for (int i = CFG_BITS-1; i >= 0; i--) begin
      gap = 0;
      if (mode == 1 && i != CFG_BITS-1) gap = 1;
      if (mode == 2) gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        step();
      end
      bit_valid = 1'b1;
      bit_in    = value[i];
      step();
      if (i != 0) chk("cen_early", {31'd0, cen}, 32'd1 - 32'd1);
    end
    bit_valid = 1'b0;
    chk("cen_after_last", {31'd0, cen}, 32'd1);
  endtask

  // Monitor: on each cen cycle pop the oldest expected frame; every cycle the
  // holding register must equal the last committed frame.
  always @(negedge cclk) begin
    if (cen) begin
      cen_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_cen", 32'd1, 32'd0);
      end else begin
        model_cfg = exp_q.pop_front();
        chk("commit_value", {24'd0, config_out}, {24'd0, model_cfg});
      end
      chk("cen_not_ready", {31'd0, bit_ready}, 32'd0);
    end
    chk("config_hold", {24'd0, config_out}, {24'd0, model_cfg});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [CFG_BITS-1:0] v;

    // Reset state
    #2;
    chk("rst_config", {24'd0, config_out}, 32'd0);
    chk("rst_cen", {31'd0, cen}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, bit_ready}, 32'd0);
    @(negedge cclk);
    rst_n = 1'b1;
    step();

    // Basic frame with bit_valid held high
    base = cen_seen;
    do_start();
    chk("start_ready", {31'd0, bit_ready}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    send_frame(8'hA5, 0);
    step();
    chk("basic_cen_one", {31'd0, cen}, 32'd0);
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_busy", {31'd0, busy}, 32'd0);
    chk("basic_pulses", cen_seen - base, 32'd1);

    // Throttled frame
    base = cen_seen;
    do_start();
    chk("start_clears_done", {31'd0, done}, 32'd0);
    send_frame(8'hA5, 1);
    step();
    chk("throttle_pulses", cen_seen - base, 32'd1);
    chk("throttle_done", {31'd0, done}, 32'd1);

    // Restart mid-frame; A5 must stay held until the new commit
    base = cen_seen;
    do_start();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      step();
    end
    start     = 1'b1;
    bit_in    = 1'b1;
    step();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("restart_held", {24'd0, config_out}, 32'hA5);
    send_frame(8'h3C, 0);
    step();
    chk("restart_pulses", cen_seen - base, 32'd1);

    // Back-to-back: start during the commit cycle of A5
    base = cen_seen;
    do_start();
    send_frame(8'hA5, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_shift", {31'd0, bit_ready}, 32'd1);
    chk("b2b_done", {31'd0, done}, 32'd0);
    send_frame(8'hFF, 0);
    step();
    chk("b2b_pulses", cen_seen - base, 32'd2);

    // Reset mid-frame
    do_start();
    send_frame(8'hA5, 0);
    step();
    do_start();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      step();
    end
    bit_valid = 1'b0;
    #2;
    model_cfg = '0;
    rst_n     = 1'b0;
    #1;
    chk("arst_config", {24'd0, config_out}, 32'd0);
    chk("arst_cen", {31'd0, cen}, 32'd0);
    chk("arst_ready", {31'd0, bit_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge cclk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_start", {31'd0, bit_ready}, 32'd1);
    send_frame(8'h5A, 0);
    step();

    // Idle noise
    base = cen_seen;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      step();
      chk("idle_ready", {31'd0, bit_ready}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd1);
    end
    bit_valid = 1'b0;
    chk("idle_no_cen", cen_seen - base, 32'd0);
    do_start();
    send_frame(8'h96, 0);
    step();

    // Randomized frames with random gaps
    for (int n = 0; n < 20; n++) begin
      v = 8'($urandom);
      do_start();
      send_frame(v, 2);
      step();
    end

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
